// File: rtl/instr_encoder.sv
// instr_encoder: turns op requests into MIPS words and writes them to imem at a rising address; INSTR_ENC_ERRCHK_EN rejects op 15 and shifts with rs != 0.
// Latency: word on imem for the cycle after accept; backpressure: req_ready low in WRITE, FULL, or while clear is high.
module instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              CLK,
  input  logic              Reset_L,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_shamt,
  input  logic [15:0]       req_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, WRITE, FULLST} state_t;

  localparam logic [ADDR_W:0] DepthCnt = DEPTH[ADDR_W:0];

  state_t            state, stateNext;
  logic [ADDR_W-1:0] addrReg;
  logic [ADDR_W:0]   cntReg;
  logic [31:0]       wdataReg;
  logic [31:0]       encWord;
  logic              rejectOp;
  logic              loadWord, incCnt, clrCnt, errNext;

  always_comb begin
    encWord = 32'h0000_0000;
    case (req_op)
      4'd0:  encWord = {6'h00, req_rs, req_rt, req_rd, 5'd0, 6'h20};
      4'd1:  encWord = {6'h00, req_rs, req_rt, req_rd, 5'd0, 6'h21};
      4'd2:  encWord = {6'h00, req_rs, req_rt, req_rd, 5'd0, 6'h22};
      4'd3:  encWord = {6'h00, req_rs, req_rt, req_rd, 5'd0, 6'h23};
      4'd4:  encWord = {6'h00, req_rs, req_rt, req_rd, 5'd0, 6'h24};
      4'd5:  encWord = {6'h00, req_rs, req_rt, req_rd, 5'd0, 6'h25};
      4'd6:  encWord = {6'h00, req_rs, req_rt, req_rd, 5'd0, 6'h26};
      4'd7:  encWord = {6'h00, 5'd0, req_rt, req_rd, req_shamt, 6'h00};
      4'd8:  encWord = {6'h00, 5'd0, req_rt, req_rd, req_shamt, 6'h02};
      4'd9:  encWord = {6'h00, 5'd0, req_rt, req_rd, req_shamt, 6'h03};
      4'd10: encWord = {6'h08, req_rs, req_rt, req_imm};
      4'd11: encWord = {6'h09, req_rs, req_rt, req_imm};
      4'd12: encWord = {6'h0C, req_rs, req_rt, req_imm};
      4'd13: encWord = {6'h0D, req_rs, req_rt, req_imm};
      4'd14: encWord = {6'h0E, req_rs, req_rt, req_imm};
      default: encWord = 32'h0000_0000;
    endcase
  end

`ifdef INSTR_ENC_ERRCHK_EN
  logic errReg;
  assign rejectOp = (req_op == 4'd15) ||
                    ((req_op >= 4'd7) && (req_op <= 4'd9) && (req_rs != 5'd0));
  assign err      = errReg;
`else
  assign rejectOp = 1'b0;
  assign err      = 1'b0;
`endif

  always_comb begin
    stateNext = state;
    loadWord  = 1'b0;
    incCnt    = 1'b0;
    clrCnt    = 1'b0;
    errNext   = 1'b0;
    case (state)
      IDLE: begin
        if (clear) begin
          clrCnt = 1'b1;
        end else if (req_valid) begin
          if (rejectOp) begin
            errNext = 1'b1;
          end else begin
            loadWord  = 1'b1;
            stateNext = WRITE;
          end
        end
      end
      WRITE: begin
        // The write itself happens this cycle regardless of clear.
        if (clear) begin
          clrCnt    = 1'b1;
          stateNext = IDLE;
        end else begin
          incCnt    = 1'b1;
          stateNext = ((cntReg + 1'b1) == DepthCnt) ? FULLST : IDLE;
        end
      end
      FULLST: begin
        if (clear) begin
          clrCnt    = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      state    <= IDLE;
      addrReg  <= '0;
      cntReg   <= '0;
      wdataReg <= 32'h0000_0000;
    end else begin
      state <= stateNext;
      if (loadWord) wdataReg <= encWord;
      if (clrCnt) begin
        addrReg <= '0;
        cntReg  <= '0;
      end else if (incCnt) begin
        addrReg <= addrReg + 1'b1;
        cntReg  <= cntReg + 1'b1;
      end
    end
  end

`ifdef INSTR_ENC_ERRCHK_EN
  always_ff @(posedge CLK) begin
    if (!Reset_L) errReg <= 1'b0;
    else          errReg <= errNext;
  end
`endif

  assign req_ready  = (state == IDLE) && !clear;
  assign imem_we    = (state == WRITE);
  assign imem_addr  = addrReg;
  assign imem_wdata = wdataReg;
  assign count      = cntReg;
  assign full       = (state == FULLST);

endmodule
